// File: rtl/dht_rx.sv
// dht_rx: DHT11/DHT22-style single-wire sensor receiver.
// Drives the host start pulse, follows the sensor's response handshake,
// decodes 40 bits by high-pulse width and publishes humidity/temperature.
// Build option: define DHT_RX_CHECKSUM_EN to reject frames whose checksum
// byte does not match; without it the checksum byte is received and dropped.
module dht_rx #(
   parameter int CLK_DIV       = 100,
   parameter int START_LOW_US  = 18000,
   parameter int TIMEOUT_US    = 200,
   parameter int BIT_THRESH_US = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        data,
   output logic        data_oe,
   output logic        busy,
   output logic [15:0] hum,
   output logic [15:0] temp,
   output logic        valid,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam int US_LIM_A = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
   localparam int US_LIMIT = (US_LIM_A > BIT_THRESH_US) ? US_LIM_A : BIT_THRESH_US;
   localparam int US_W     = $clog2(US_LIMIT + 2);
   localparam int DIV_W    = $clog2(CLK_DIV + 1);
   localparam logic [US_W-1:0] US_MAX = '1;

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      WAIT_RESP,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      DONE
   } state_t;

   state_t            state;
   logic              data_s1;
   logic              data_s2;
   logic              data_prev;
   logic              fall;
   logic              rise;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic [US_W-1:0]   us_cnt;
   logic [US_W-1:0]   us_next;
   logic              timeout;
   logic              bit_val;
   logic [5:0]        bit_cnt;
   logic [31:0]       frame;
`ifdef DHT_RX_CHECKSUM_EN
   logic [7:0]        chk_byte;
   logic [7:0]        chk_sum;
`endif

   // Bring the asynchronous bus level into the clk domain; idle bus is high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_s1   <= 1'b1;
         data_s2   <= 1'b1;
         data_prev <= 1'b1;
      end else begin
         data_s1   <= data;
         data_s2   <= data_s1;
         data_prev <= data_s2;
      end
   end

   // Edge strobes, the microsecond tick and the elapsed time including this cycle's tick.
   always_comb begin
      fall    = data_prev & ~data_s2;
      rise    = ~data_prev & data_s2;
      tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
      us_next = (tick && (us_cnt != US_MAX)) ? us_cnt + US_W'(1) : us_cnt;
      timeout = tick && (us_next == US_W'(TIMEOUT_US));
      bit_val = (us_next > US_W'(BIT_THRESH_US));
   end

`ifdef DHT_RX_CHECKSUM_EN
   // Checksum is the low byte of the sum of the four data bytes.
   always_comb begin
      chk_sum = frame[31:24] + frame[23:16] + frame[15:8] + frame[7:0];
   end
`endif

   // Transaction sequencer; every state change restarts the prescaler and us counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         data_oe  <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'b00;
         hum      <= '0;
         temp     <= '0;
         div_cnt  <= '0;
         us_cnt   <= '0;
         bit_cnt  <= '0;
         frame    <= '0;
`ifdef DHT_RX_CHECKSUM_EN
         chk_byte <= '0;
`endif
      end else begin
         valid   <= 1'b0;
         err     <= 1'b0;
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
         us_cnt  <= us_next;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= START_LOW;
                  data_oe <= 1'b1;
                  busy    <= 1'b1;
                  bit_cnt <= '0;
                  div_cnt <= '0;
                  us_cnt  <= '0;
               end
            end
            START_LOW: begin
               if (tick && (us_next == US_W'(START_LOW_US))) begin
                  state   <= WAIT_RESP;
                  data_oe <= 1'b0;
                  div_cnt <= '0;
                  us_cnt  <= '0;
               end
            end
            WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH: begin
               if ((state == RESP_LOW || state == BIT_LOW) ? rise : fall) begin
                  div_cnt <= '0;
                  us_cnt  <= '0;
                  case (state)
                     WAIT_RESP: state <= RESP_LOW;
                     RESP_LOW:  state <= RESP_HIGH;
                     RESP_HIGH: state <= BIT_LOW;
                     BIT_LOW:   state <= BIT_HIGH;
                     default: begin
                        if (bit_cnt < 6'd32) begin
                           frame <= {frame[30:0], bit_val};
                        end
`ifdef DHT_RX_CHECKSUM_EN
                        else begin
                           chk_byte <= {chk_byte[6:0], bit_val};
                        end
`endif
                        bit_cnt <= bit_cnt + 6'd1;
                        state   <= (bit_cnt == 6'd39) ? DONE : BIT_LOW;
                     end
                  endcase
               end else if (timeout) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  err      <= 1'b1;
                  err_code <= 2'b01;
                  div_cnt  <= '0;
                  us_cnt   <= '0;
               end
            end
            DONE: begin
`ifdef DHT_RX_CHECKSUM_EN
               if (chk_sum == chk_byte) begin
                  hum   <= frame[31:16];
                  temp  <= frame[15:0];
                  valid <= 1'b1;
               end else begin
                  err      <= 1'b1;
                  err_code <= 2'b10;
               end
`else
               hum   <= frame[31:16];
               temp  <= frame[15:0];
               valid <= 1'b1;
`endif
               state   <= IDLE;
               busy    <= 1'b0;
               div_cnt <= '0;
               us_cnt  <= '0;
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               data_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dht_rx.sv
// tb_dht_rx: directed bench for dht_rx with a behavioural sensor on the bus.
// Runs with shortened timing parameters so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_dht_rx;

   localparam int CLK_DIV_TB   = 2;
   localparam int START_LOW_TB = 20;
   localparam int TIMEOUT_TB   = 100;
   localparam int THRESH_TB    = 50;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sensor_level;
   logic        data;
   logic        data_oe;
   logic        busy;
   logic [15:0] hum;
   logic [15:0] temp;
   logic        valid;
   logic        err;
   logic [1:0]  err_code;

   int check_cnt  = 0;
   int error_cnt  = 0;
   int valid_cnt  = 0;
   int err_cnt    = 0;
   int both_cnt   = 0;
   int oe_rise    = 0;
   int oe_run     = 0;
   int oe_len     = 0;
   logic [1:0] last_code = 2'b00;
   logic oe_prev = 1'b0;

   // Open-drain bus: the host pulls low when enabled, otherwise the sensor sets the level.
   assign data = data_oe ? 1'b0 : sensor_level;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   dht_rx #(
      .CLK_DIV       (CLK_DIV_TB),
      .START_LOW_US  (START_LOW_TB),
      .TIMEOUT_US    (TIMEOUT_TB),
      .BIT_THRESH_US (THRESH_TB)
   ) dut (
      .clk      (clk),
      .rst      (rst_n),
      .start    (start),
      .data     (data),
      .data_oe  (data_oe),
      .busy     (busy),
      .hum      (hum),
      .temp     (temp),
      .valid    (valid),
      .err      (err),
      .err_code (err_code)
   );

   // Tally strobes and measure how long the host holds the bus low.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) valid_cnt++;
         if (err) begin
            err_cnt++;
            last_code = err_code;
         end
         if (valid && err) both_cnt++;
         if (data_oe && !oe_prev) oe_rise++;
         if (data_oe) oe_run++;
         else if (oe_run != 0) begin
            oe_len = oe_run;
            oe_run = 0;
         end
      end
      oe_prev = data_oe;
   end

   // Hard stop in case the sequence below stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_cnt++;
      if (observed !== expected) begin
         error_cnt++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitUs(input int us);
      repeat (us * CLK_DIV_TB) @(negedge clk);
   endtask

   task automatic pulseStart();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // Returns at the first sampled cycle with the bus released.
   task automatic waitRelease(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < START_LOW_TB * CLK_DIV_TB + 20; i++) begin
         @(negedge clk);
         if (!data_oe) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // One full transaction: start pulse, sensor response, then 40 bits MSB first.
   task automatic applyStimulus(input logic [39:0] frame, input int hi0, input int hi1,
                                input bit extra_start, input int abort_bit);
      bit ok;
      pulseStart();
      if (extra_start) begin
         repeat (3) @(negedge clk);
         pulseStart();
      end
      waitRelease(ok);
      checkOutput("bus_release", 32'(ok), 32'd1);
      if (!ok) return;
      waitUs(30);
      sensor_level = 1'b0;
      waitUs(80);
      sensor_level = 1'b1;
      waitUs(80);
      for (int i = 0; i < 40; i++) begin
         sensor_level = 1'b0;
         if (i == abort_bit) begin
            waitUs(20);
            rst_n = 1'b0;
            #1;
            checkOutput("abort_data_oe", 32'(data_oe), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_hum", 32'(hum), 32'h0);
            sensor_level = 1'b1;
            waitUs(5);
            rst_n = 1'b1;
            return;
         end
         waitUs(50);
         sensor_level = 1'b1;
         waitUs(frame[39-i] ? hi1 : hi0);
      end
      sensor_level = 1'b0;
      waitUs(50);
      sensor_level = 1'b1;
      waitUs(10);
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      int v0;
      int e0;
      int k;
      bit ok;
      rst_n        = 1'b0;
      start        = 1'b0;
      sensor_level = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("rst_data_oe", 32'(data_oe), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_err_code", 32'(err_code), 32'd0);
      checkOutput("rst_hum", 32'(hum), 32'h0);
      checkOutput("rst_temp", 32'(temp), 32'h0);
      rst_n = 1'b1;
      waitUs(5);

      $display("[TB] good frame with a second start while busy");
      v0 = valid_cnt;
      e0 = err_cnt;
      applyStimulus(40'h37_00_19_05_55, 26, 70, 1'b1, -1);
      checkOutput("start_low_cycles", 32'(oe_len), 32'd40);
      checkOutput("f1_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      checkOutput("f1_err_pulses", 32'(err_cnt - e0), 32'd0);
      checkOutput("f1_hum", 32'(hum), 32'h3700);
      checkOutput("f1_temp", 32'(temp), 32'h1905);
      checkOutput("f1_busy_after", 32'(busy), 32'd0);
      waitUs(50);
      checkOutput("single_transaction", 32'(oe_rise), 32'd1);

      $display("[TB] threshold frame, zeros 50 us high, ones 51 us high");
      v0 = valid_cnt;
      applyStimulus(40'h12_34_56_78_14, 50, 51, 1'b0, -1);
      checkOutput("thr_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      checkOutput("thr_hum", 32'(hum), 32'h1234);
      checkOutput("thr_temp", 32'(temp), 32'h5678);

      $display("[TB] frame with wrong checksum byte");
      v0 = valid_cnt;
      e0 = err_cnt;
      applyStimulus(40'h37_00_19_05_56, 26, 70, 1'b0, -1);
`ifdef DHT_RX_CHECKSUM_EN
      checkOutput("chk_err_pulses", 32'(err_cnt - e0), 32'd1);
      checkOutput("chk_valid_pulses", 32'(valid_cnt - v0), 32'd0);
      checkOutput("chk_err_code", 32'(last_code), 32'd2);
      checkOutput("chk_hum_held", 32'(hum), 32'h1234);
      checkOutput("chk_temp_held", 32'(temp), 32'h5678);
`else
      checkOutput("nochk_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      checkOutput("nochk_err_pulses", 32'(err_cnt - e0), 32'd0);
      checkOutput("nochk_hum", 32'(hum), 32'h3700);
      checkOutput("nochk_temp", 32'(temp), 32'h1905);
`endif

      $display("[TB] silent sensor");
      e0 = err_cnt;
      pulseStart();
      waitRelease(ok);
      checkOutput("to_release", 32'(ok), 32'd1);
      k = 0;
      while (!err && k < 1000) begin
         @(negedge clk);
         k++;
      end
      checkOutput("to_cycles", 32'(k), 32'(TIMEOUT_TB * CLK_DIV_TB));
      checkOutput("to_err_code", 32'(err_code), 32'd1);
      @(negedge clk);
      checkOutput("to_busy_after", 32'(busy), 32'd0);
      checkOutput("to_err_pulses", 32'(err_cnt - e0), 32'd1);
      waitUs(20);
      checkOutput("to_err_code_held", 32'(err_code), 32'd1);
`ifdef DHT_RX_CHECKSUM_EN
      checkOutput("to_hum_held", 32'(hum), 32'h1234);
`else
      checkOutput("to_hum_held", 32'(hum), 32'h3700);
`endif

      $display("[TB] reset at bit 20, then a clean frame");
      applyStimulus(40'h37_00_19_05_55, 26, 70, 1'b0, 20);
      waitUs(20);
      v0 = valid_cnt;
      applyStimulus(40'h41_02_1A_03_60, 26, 70, 1'b0, -1);
      checkOutput("post_rst_valid_pulses", 32'(valid_cnt - v0), 32'd1);
      checkOutput("post_rst_hum", 32'(hum), 32'h4102);
      checkOutput("post_rst_temp", 32'(temp), 32'h1A03);
      checkOutput("valid_err_overlap", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
      $finish;
   end

endmodule
